// File: rtl/step0_ctrl_pkg.sv
// Shared constants and types for the step0 FFT stage sequencing controller.
package step0_ctrl_pkg;

   localparam int HALF     = 16;
   localparam int AW       = $clog2(HALF);
   localparam int FRAME    = 2 * HALF;
   localparam int SAMPLE_W = 9;
   localparam int BFLY_W   = 10;

   typedef enum logic {
      FILL = 1'b0,
      BFLY = 1'b1
   } state_t;

endpackage

// File: rtl/step0_ctrl_if.sv
// Block buffer, butterfly and output-stream control bundle of step0_0.
// master = controller side, slave = framer/datapath side.
interface step0_ctrl_if;
   import step0_ctrl_pkg::*;

   logic          din_valid;
   logic          buf_wr_en;
   logic          buf_wr_sel;
   logic [AW-1:0] buf_wr_addr;
   logic [AW-1:0] buf_rd_addr;
   logic          bfly_en;
   logic          dout_valid;
   logic          dout_sel;
   logic [AW:0]   dout_idx;
   logic          frame_done;
   logic          busy;

   modport master (
      input  din_valid,
      output buf_wr_en, buf_wr_sel, buf_wr_addr, buf_rd_addr, bfly_en,
      output dout_valid, dout_sel, dout_idx, frame_done, busy
   );

   modport slave (
      output din_valid,
      input  buf_wr_en, buf_wr_sel, buf_wr_addr, buf_rd_addr, bfly_en,
      input  dout_valid, dout_sel, dout_idx, frame_done, busy
   );

endinterface

// File: rtl/step0_drain_ctr.sv
// Drain engine: once armed, steps through HALF buffer addresses on
// consecutive cycles regardless of input flow, then idles.
module step0_drain_ctr
   import step0_ctrl_pkg::*;
(
   input  logic          i_clk,
   input  logic          i_rstn,
   input  logic          i_arm,
   output logic [AW-1:0] o_cnt,
   output logic          o_active,
   output logic          o_last
);

   logic [AW-1:0] r_cnt;
   logic          r_active;
   logic          w_last;

   assign w_last = r_active && (r_cnt == AW'(HALF - 1));

   // Arm restarts at address 0; the counter self-disarms after its last step.
   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         r_cnt    <= '0;
         r_active <= 1'b0;
      end else if (i_arm) begin
         r_cnt    <= '0;
         r_active <= 1'b1;
      end else if (r_active) begin
         r_cnt <= w_last ? '0 : r_cnt + 1'b1;
         if (w_last) begin
            r_active <= 1'b0;
         end
      end
   end

   assign o_cnt    = r_cnt;
   assign o_active = r_active;
   assign o_last   = w_last;

endmodule

// File: rtl/step0_ctrl.sv
// Sequencing controller for FFT stage step0_0: counts input blocks, drives
// the block buffer ports and butterfly enable, and schedules the output
// stream (add results direct, parked sub results drained afterwards).
//
//   state | meaning
//   ------+------------------------------------------------------------
//   FILL  | in_cnt < HALF: input blocks are stored at address in_cnt
//   BFLY  | in_cnt >= HALF: block pairs with stored block in_cnt-HALF,
//         | sub result written back in place, add result sent out
module step0_ctrl
   import step0_ctrl_pkg::*;
(
   input  logic          i_clk,
   input  logic          i_rstn,
   step0_ctrl_if.master  bus
);

   state_t        r_state;
   logic [AW:0]   r_in_cnt;
   logic          r_dout_valid;
   logic          r_dout_sel;
   logic [AW:0]   r_dout_idx;
   logic          r_frame_done;

   logic          w_fill_wr;
   logic          w_bfly;
   logic          w_last_in;
   logic [AW-1:0] w_bfly_addr;
   logic [AW-1:0] w_drain_cnt;
   logic          w_drain_active;
   logic          w_drain_last;

   assign w_fill_wr   = bus.din_valid && (r_state == FILL);
   assign w_bfly      = bus.din_valid && (r_state == BFLY);
   assign w_last_in   = w_bfly && (r_in_cnt == (AW+1)'(FRAME - 1));
   assign w_bfly_addr = AW'(r_in_cnt - (AW+1)'(HALF));

   step0_drain_ctr u_drain (
      .i_clk    (i_clk),
      .i_rstn   (i_rstn),
      .i_arm    (w_last_in),
      .o_cnt    (w_drain_cnt),
      .o_active (w_drain_active),
      .o_last   (w_drain_last)
   );

   // Input-side block counter and FILL/BFLY phase; frozen while din_valid is low.
   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         r_state  <= FILL;
         r_in_cnt <= '0;
      end else if (bus.din_valid) begin
         r_in_cnt <= (r_in_cnt == (AW+1)'(FRAME - 1)) ? '0 : r_in_cnt + 1'b1;
         if (r_state == FILL) begin
            if (r_in_cnt == (AW+1)'(HALF - 1)) begin
               r_state <= BFLY;
            end
         end else begin
            if (r_in_cnt == (AW+1)'(FRAME - 1)) begin
               r_state <= FILL;
            end
         end
      end
   end

   // Output stream descriptor, one cycle behind the butterfly / drain step
   // to line up with the datapath output register. Drain and BFLY never
   // coincide because FILL lasts at least HALF cycles.
   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         r_dout_valid <= 1'b0;
         r_dout_sel   <= 1'b0;
         r_dout_idx   <= '0;
         r_frame_done <= 1'b0;
      end else begin
         r_dout_valid <= w_bfly || w_drain_active;
         r_dout_sel   <= w_drain_active;
         r_frame_done <= w_drain_last;
         if (w_drain_active) begin
            r_dout_idx <= (AW+1)'(HALF) + {1'b0, w_drain_cnt};
         end else if (w_bfly) begin
            r_dout_idx <= {1'b0, w_bfly_addr};
         end else begin
            r_dout_idx <= '0;
         end
      end
   end

   assign bus.buf_wr_en   = w_fill_wr || w_bfly;
   assign bus.buf_wr_sel  = w_bfly;
   assign bus.buf_wr_addr = w_fill_wr ? r_in_cnt[AW-1:0] :
                            w_bfly    ? w_bfly_addr       : '0;
   assign bus.buf_rd_addr = w_drain_active ? w_drain_cnt :
                            w_bfly         ? w_bfly_addr : '0;
   assign bus.bfly_en     = w_bfly;

   assign bus.dout_valid  = r_dout_valid;
   assign bus.dout_sel    = r_dout_sel;
   assign bus.dout_idx    = r_dout_idx;
   assign bus.frame_done  = r_frame_done;
   assign bus.busy        = (r_in_cnt != '0) || w_drain_active || r_dout_valid;

endmodule

// File: tb/tb_step0_ctrl.sv
// Bench for step0_ctrl: directed block sequences, same-cycle strobe checks,
// and a scoreboard of expected output descriptors (with arrival cycle)
// consumed by an independent monitor.
module tb_step0_ctrl;
   import step0_ctrl_pkg::*;

   typedef struct {
      logic        sel;
      logic [AW:0] idx;
      logic        done;
      int          cyc;
   } exp_t;

   logic clk;
   logic rstn;
   int   cyc;
   int   n_checks;
   int   n_errors;
   logic mon_en;
   exp_t q[$];

   int   m_cnt;
   logic m_drain_on;
   int   m_ptr;
   logic m_dv;

   step0_ctrl_if bus_if ();

   step0_ctrl dut (
      .i_clk  (clk),
      .i_rstn (rstn),
      .bus    (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: consumes expected output descriptors whenever the DUT shows one.
   always @(negedge clk) begin
      if (mon_en) begin
         if (bus_if.dout_valid === 1'b1) begin
            if (q.size() == 0) begin
               chk("dout_unexpected", bus_if.dout_valid, 0);
            end else begin
               exp_t e;
               e = q.pop_front();
               chk("dout_cycle", cyc, e.cyc);
               chk("dout_sel", bus_if.dout_sel, e.sel);
               chk("dout_idx", bus_if.dout_idx, e.idx);
               chk("frame_done", bus_if.frame_done, e.done);
            end
         end else begin
            chk("frame_done_idle", bus_if.frame_done, 0);
            if (q.size() != 0 && q[0].cyc <= cyc) begin
               chk("dout_missing", bus_if.dout_valid, 1);
               void'(q.pop_front());
            end
         end
      end
   end

   task automatic model_clear();
      m_cnt      = 0;
      m_drain_on = 1'b0;
      m_ptr      = 0;
      m_dv       = 1'b0;
      q.delete();
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      rstn             = 1'b0;
      bus_if.din_valid = 1'b0;
      @(posedge clk);
      #1;
      rstn = 1'b1;
      model_clear();
      #2;
      chk("rst_dout_valid", bus_if.dout_valid, 0);
      chk("rst_dout_sel", bus_if.dout_sel, 0);
      chk("rst_dout_idx", bus_if.dout_idx, 0);
      chk("rst_frame_done", bus_if.frame_done, 0);
      chk("rst_busy", bus_if.busy, 0);
      chk("rst_wr_en", bus_if.buf_wr_en, 0);
      chk("rst_bfly_en", bus_if.bfly_en, 0);
      chk("rst_wr_addr", bus_if.buf_wr_addr, 0);
      chk("rst_rd_addr", bus_if.buf_rd_addr, 0);
   endtask

   // One clock cycle of stimulus with same-cycle strobe checks.
   task automatic step(input logic v);
      logic e_bfly;
      int   e_wr_addr;
      int   e_rd_addr;
      logic e_busy;
      logic next_dv;
      @(posedge clk);
      #1;
      bus_if.din_valid = v;
      #2;
      e_bfly    = v && (m_cnt >= HALF);
      e_wr_addr = v ? (m_cnt % HALF) : 0;
      e_rd_addr = m_drain_on ? m_ptr : (e_bfly ? m_cnt - HALF : 0);
      e_busy    = (m_cnt != 0) || m_drain_on || m_dv;
      chk("buf_wr_en", bus_if.buf_wr_en, v);
      chk("buf_wr_sel", bus_if.buf_wr_sel, e_bfly);
      chk("buf_wr_addr", bus_if.buf_wr_addr, e_wr_addr);
      chk("bfly_en", bus_if.bfly_en, e_bfly);
      chk("buf_rd_addr", bus_if.buf_rd_addr, e_rd_addr);
      chk("busy", bus_if.busy, e_busy);
      if (e_bfly) begin
         q.push_back('{sel: 1'b0, idx: (AW+1)'(m_cnt - HALF), done: 1'b0, cyc: cyc + 1});
      end
      if (m_drain_on) begin
         q.push_back('{sel: 1'b1, idx: (AW+1)'(HALF + m_ptr), done: (m_ptr == HALF - 1), cyc: cyc + 1});
      end
      next_dv = e_bfly || m_drain_on;
      if (m_drain_on) begin
         if (m_ptr == HALF - 1) m_drain_on = 1'b0;
         m_ptr++;
      end
      if (v && m_cnt == FRAME - 1) begin
         m_drain_on = 1'b1;
         m_ptr      = 0;
      end
      if (v) m_cnt = (m_cnt + 1) % FRAME;
      m_dv = next_dv;
   endtask

   initial begin
      n_checks         = 0;
      n_errors         = 0;
      mon_en           = 1'b0;
      rstn             = 1'b0;
      bus_if.din_valid = 1'b0;
      model_clear();

      do_reset();
      mon_en = 1'b1;

      // gap-free frame, then idle through drain
      repeat (FRAME) step(1'b1);
      repeat (HALF + 4) step(1'b0);

      // same frame with a gap every other cycle
      for (int i = 0; i < 2 * FRAME; i++) step(i % 2 == 0);
      repeat (HALF + 4) step(1'b0);

      // two back-to-back frames: drain overlaps next fill
      repeat (2 * FRAME) step(1'b1);
      repeat (HALF + 4) step(1'b0);

      // reset in the middle of a frame, then a clean frame
      repeat (HALF + 4) step(1'b1);
      do_reset();
      repeat (3) step(1'b1);
      repeat (2) step(1'b0);
      repeat (FRAME - 3) step(1'b1);
      repeat (HALF + 6) step(1'b0);

      chk("scoreboard_empty", q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
